// File: rtl/gcd_rr_scheduler.sv
// Round-robin front end sharing one iterative gcd core among NREQ requesters.
// Trivial operand pairs (either operand zero) are answered locally without touching the core.
module gcd_rr_scheduler #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 18,
    parameter int unsigned IDW  = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*W-1:0]    req_a,
    input  logic [NREQ*W-1:0]    req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 resp_valid,
    output logic [IDW-1:0]       resp_id,
    output logic [W-1:0]         resp_data,
    output logic                 busy,
    output logic                 gcd_start,
    output logic [W-1:0]         gcd_a,
    output logic [W-1:0]         gcd_b,
    input  logic [W-1:0]         gcd_result,
    input  logic                 gcd_result_ready
);

    localparam int unsigned PTR_RST = NREQ - 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [W-1:0]   opa_q, opa_d;
    logic [W-1:0]   opb_q, opb_d;
    logic           resp_valid_q, resp_valid_d;
    logic [IDW-1:0] resp_id_q, resp_id_d;
    logic [W-1:0]   resp_data_q, resp_data_d;
    logic           busy_q, busy_d;
    logic           start_q, start_d;

    logic           found;
    logic [IDW-1:0] win;
    logic [W-1:0]   grant_a, grant_b;

    // Index of the k-th requester after base, wrapping modulo NREQ.
    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int unsigned k);
        int unsigned s;
        s = 32'(base) + k;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IDW'(s);
    endfunction

    // First valid requester scanning ptr+1, ptr+2, ... so the last winner has lowest priority.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!found && req_valid[rr_index(ptr_q, k)]) begin
                found = 1'b1;
                win   = rr_index(ptr_q, k);
            end
        end
    end

    assign grant_a = req_a[32'(win)*W +: W];
    assign grant_b = req_b[32'(win)*W +: W];

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        resp_valid_d = 1'b0;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        req_ready    = '0;

        unique case (state_q)
            ST_IDLE: begin
                // A busy core (e.g. left running across a reset) blocks every grant, bypass included.
                if (reset_n && gcd_result_ready && found) begin
                    req_ready[win] = 1'b1;
                    ptr_d          = win;
                    id_d           = win;
                    opa_d          = grant_a;
                    opb_d          = grant_b;
                    if (grant_a == '0 || grant_b == '0) begin
                        resp_valid_d = 1'b1;
                        resp_id_d    = win;
                        resp_data_d  = grant_a | grant_b;
                    end else begin
                        state_d = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (gcd_result_ready) begin
                    resp_valid_d = 1'b1;
                    resp_id_d    = id_q;
                    resp_data_d  = gcd_result;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d  = (state_d != ST_IDLE);
        start_d = (state_d == ST_LAUNCH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= IDW'(PTR_RST);
            id_q         <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            busy_q       <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            busy_q       <= busy_d;
            start_q      <= start_d;
        end
    end

    // Operand registers only change on a grant, which cannot happen in LAUNCH or WAIT.
    assign gcd_a      = opa_q;
    assign gcd_b      = opb_q;
    assign gcd_start  = start_q;
    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// Directed bench for gcd_rr_scheduler with a behavioural gcd core and per-requester job lists.
module tb_gcd_rr_scheduler;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 18;
    localparam int unsigned IDW  = 2;

    logic                clk;
    logic                reset_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*W-1:0]   req_a;
    logic [NREQ*W-1:0]   req_b;
    logic [NREQ-1:0]     req_ready;
    logic                resp_valid;
    logic [IDW-1:0]      resp_id;
    logic [W-1:0]        resp_data;
    logic                busy;
    logic                gcd_start;
    logic [W-1:0]        gcd_a;
    logic [W-1:0]        gcd_b;
    logic [W-1:0]        gcd_result;
    logic                gcd_result_ready;

    gcd_rr_scheduler #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_a            (req_a),
        .req_b            (req_b),
        .req_ready        (req_ready),
        .resp_valid       (resp_valid),
        .resp_id          (resp_id),
        .resp_data        (resp_data),
        .busy             (busy),
        .gcd_start        (gcd_start),
        .gcd_a            (gcd_a),
        .gcd_b            (gcd_b),
        .gcd_result       (gcd_result),
        .gcd_result_ready (gcd_result_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural core: no reset, samples operands the cycle after start, fixed latency.
    logic [W-1:0] core_res   = '0;
    logic [W-1:0] core_x     = '0;
    logic [W-1:0] core_y     = '0;
    logic         core_ready = 1'b1;
    logic         force_busy = 1'b0;
    int           core_phase = 0;
    int           core_cnt   = 0;
    int           core_lat   = 6;

    function automatic logic [W-1:0] gcd_fn(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != '0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    always @(posedge clk) begin
        if (gcd_start === 1'b1) begin
            core_ready <= 1'b0;
            core_phase <= 1;
        end else if (core_phase == 1) begin
            core_x     <= gcd_a;
            core_y     <= gcd_b;
            core_cnt   <= core_lat;
            core_phase <= 2;
        end else if (core_phase == 2) begin
            if (core_cnt <= 1) begin
                core_res   <= gcd_fn(core_x, core_y);
                core_ready <= 1'b1;
                core_phase <= 0;
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
    end

    assign gcd_result       = core_res;
    assign gcd_result_ready = core_ready & ~force_busy;

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;

    int g_id[$];
    int g_cyc[$];
    int r_id[$];
    int r_data[$];
    int r_cyc[$];
    int s_cyc[$];
    int last_grant;
    int hold_cyc, hold_bad, busy_bad, multi_bad, grant_while_busy, blocked;
    logic [W-1:0] exp_ga, exp_gb;

    logic [W-1:0] ja[NREQ][4];
    logic [W-1:0] jb[NREQ][4];
    int           jn[NREQ];
    int           jp[NREQ];

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic clear_log();
        g_id.delete(); g_cyc.delete(); r_id.delete(); r_data.delete(); r_cyc.delete(); s_cyc.delete();
        hold_cyc = 0; hold_bad = 0; busy_bad = 0; multi_bad = 0; grant_while_busy = 0; blocked = 0;
        for (int i = 0; i < NREQ; i++) begin
            jn[i] = 0;
            jp[i] = 0;
        end
    endtask

    task automatic add_job(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
        ja[r][jn[r]] = a;
        jb[r][jn[r]] = b;
        jn[r]++;
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < NREQ; i++) begin
            if (jp[i] < jn[i]) begin
                req_valid[i]     = 1'b1;
                req_a[i*W +: W]  = ja[i][jp[i]];
                req_b[i*W +: W]  = jb[i][jp[i]];
            end else begin
                req_valid[i]     = 1'b0;
                req_a[i*W +: W]  = '0;
                req_b[i*W +: W]  = '0;
            end
        end
    endtask

    // One clock: observe at the falling edge, return just after the next rising edge.
    task automatic step();
        int ones;
        @(negedge clk);
        cyc++;
        last_grant = -1;
        ones = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i] === 1'b1) begin
                last_grant = i;
                ones++;
            end
        end
        if (ones > 1) multi_bad++;
        if (req_valid != '0 && gcd_result_ready !== 1'b1) blocked++;
        if (last_grant >= 0) begin
            g_id.push_back(last_grant);
            g_cyc.push_back(cyc);
            if (gcd_result_ready !== 1'b1) grant_while_busy++;
            if (req_a[last_grant*W +: W] != '0 && req_b[last_grant*W +: W] != '0) begin
                exp_ga = req_a[last_grant*W +: W];
                exp_gb = req_b[last_grant*W +: W];
            end
        end
        if (resp_valid === 1'b1) begin
            r_id.push_back(int'(resp_id));
            r_data.push_back(int'(resp_data));
            r_cyc.push_back(cyc);
        end
        if (gcd_start === 1'b1) begin
            s_cyc.push_back(cyc);
            if (busy !== 1'b1) busy_bad++;
        end
        if (busy === 1'b1) begin
            hold_cyc++;
            if (gcd_a !== exp_ga || gcd_b !== exp_gb) hold_bad++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic serve(input int nresp, input int budget);
        int base;
        base = r_id.size();
        apply_inputs();
        for (int c = 0; c < budget; c++) begin
            step();
            if (last_grant >= 0) begin
                jp[last_grant]++;
                apply_inputs();
            end
            if (r_id.size() - base >= nresp) break;
        end
    endtask

    task automatic apply_reset();
        req_valid = '0; req_a = '0; req_b = '0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        req_valid = '1;
        req_a = {4{18'd21}};
        req_b = {4{18'd14}};
        reset_n = 1'b0;
        #12;
        n_chk++;
        if ({req_ready, resp_valid, resp_id, resp_data, busy, gcd_start, gcd_a, gcd_b} !== '0)
            $display("FAIL reset_outputs: got rdy=%b rv=%b id=%0d data=%0d busy=%b start=%b a=%0d b=%0d, all 0 required",
                     req_ready, resp_valid, resp_id, resp_data, busy, gcd_start, gcd_a, gcd_b);
        else n_pass++;
        clear_log();
        step();
        n_chk++;
        if (g_id.size() != 0) $display("FAIL reset_no_grant: got %0d grants, 0 required", g_id.size());
        else n_pass++;
        req_valid = '0; req_a = '0; req_b = '0;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        clear_log();
        add_job(0, 18'd12, 18'd18);
        serve(1, 60);
        n_chk++;
        if (g_id.size() != 1 || qget(g_id, 0) != 0) $display("FAIL single_grant: got n=%0d id=%0d, n=1 id=0 required", g_id.size(), qget(g_id, 0));
        else n_pass++;
        n_chk++;
        if (s_cyc.size() != 1 || qget(s_cyc, 0) != qget(g_cyc, 0) + 1)
            $display("FAIL single_start: got n=%0d cyc=%0d, n=1 cyc=%0d required", s_cyc.size(), qget(s_cyc, 0), qget(g_cyc, 0) + 1);
        else n_pass++;
        n_chk++;
        if (qget(r_id, 0) !== 0) $display("FAIL single_id: got %0d, 0 required", qget(r_id, 0));
        else n_pass++;
        n_chk++;
        if (qget(r_data, 0) !== 6) $display("FAIL single_data: got %0d, 6 required", qget(r_data, 0));
        else n_pass++;
        n_chk++;
        if (hold_cyc < 3 || hold_bad != 0 || exp_ga !== 18'd12 || exp_gb !== 18'd18)
            $display("FAIL single_hold: got busy cycles=%0d bad=%0d, >=3 cycles and 0 bad of 12/18 required", hold_cyc, hold_bad);
        else n_pass++;
        n_chk++;
        if (busy_bad != 0) $display("FAIL single_busy_launch: got %0d start cycles without busy, 0 required", busy_bad);
        else n_pass++;
        n_chk++;
        if (busy !== 1'b0) $display("FAIL single_busy_done: got %b, 0 required", busy);
        else n_pass++;
    endtask

    task automatic test_bypass();
        clear_log();
        add_job(2, 18'd0, 18'd35);
        add_job(2, 18'd0, 18'd0);
        serve(2, 20);
        n_chk++;
        if (g_id.size() != 2 || qget(g_id, 0) != 2 || qget(g_id, 1) != 2)
            $display("FAIL bypass_grants: got n=%0d ids=%0d,%0d, 2,2 required", g_id.size(), qget(g_id, 0), qget(g_id, 1));
        else n_pass++;
        n_chk++;
        if (qget(r_data, 0) !== 35 || qget(r_id, 0) !== 2) $display("FAIL bypass_resp0: got data=%0d id=%0d, 35/2 required", qget(r_data, 0), qget(r_id, 0));
        else n_pass++;
        n_chk++;
        if (qget(r_cyc, 0) !== qget(g_cyc, 0) + 1) $display("FAIL bypass_latency: got resp cyc %0d, %0d required", qget(r_cyc, 0), qget(g_cyc, 0) + 1);
        else n_pass++;
        n_chk++;
        if (qget(r_data, 1) !== 0 || qget(r_id, 1) !== 2) $display("FAIL bypass_zero: got data=%0d id=%0d, 0/2 required", qget(r_data, 1), qget(r_id, 1));
        else n_pass++;
        n_chk++;
        if (s_cyc.size() != 0 || busy_bad != 0 || hold_cyc != 0)
            $display("FAIL bypass_no_core: got starts=%0d busy cycles=%0d, 0/0 required", s_cyc.size(), hold_cyc);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int exp_d[4];
        int exp_g[3];
        int exp_d2[3];
        exp_d  = '{12, 1, 25, 9};
        exp_g  = '{1, 3, 1};
        exp_d2 = '{4, 5, 7};
        apply_reset();
        clear_log();
        add_job(0, 18'd48, 18'd36);
        add_job(1, 18'd7, 18'd5);
        add_job(2, 18'd100, 18'd75);
        add_job(3, 18'd9, 18'd27);
        serve(4, 200);
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (qget(g_id, k) !== k || qget(r_id, k) !== k)
                $display("FAIL rr_order[%0d]: got grant=%0d resp id=%0d, %0d required", k, qget(g_id, k), qget(r_id, k), k);
            else n_pass++;
            n_chk++;
            if (qget(r_data, k) !== exp_d[k]) $display("FAIL rr_data[%0d]: got %0d, %0d required", k, qget(r_data, k), exp_d[k]);
            else n_pass++;
        end
        n_chk++;
        if (qget(g_cyc, 1) !== qget(r_cyc, 0)) $display("FAIL rr_regrant_gap: got grant cyc %0d, %0d required", qget(g_cyc, 1), qget(r_cyc, 0));
        else n_pass++;
        clear_log();
        add_job(1, 18'd8, 18'd12);
        add_job(1, 18'd14, 18'd21);
        add_job(3, 18'd15, 18'd25);
        serve(3, 200);
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (qget(g_id, k) !== exp_g[k] || qget(r_data, k) !== exp_d2[k] || qget(r_id, k) !== exp_g[k])
                $display("FAIL rr_pair[%0d]: got grant=%0d id=%0d data=%0d, id %0d data %0d required",
                         k, qget(g_id, k), qget(r_id, k), qget(r_data, k), exp_g[k], exp_d2[k]);
            else n_pass++;
        end
        n_chk++;
        if (multi_bad != 0) $display("FAIL rr_onehot: got %0d multi-bit req_ready cycles, 0 required", multi_bad);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        clear_log();
        add_job(0, 18'd0, 18'd5);
        add_job(1, 18'd6, 18'd0);
        serve(2, 20);
        n_chk++;
        if (qget(g_id, 0) !== 0 || qget(g_id, 1) !== 1) $display("FAIL b2b_grants: got %0d,%0d, 0,1 required", qget(g_id, 0), qget(g_id, 1));
        else n_pass++;
        n_chk++;
        if (qget(g_cyc, 1) !== qget(g_cyc, 0) + 1) $display("FAIL b2b_consecutive: got cyc %0d, %0d required", qget(g_cyc, 1), qget(g_cyc, 0) + 1);
        else n_pass++;
        n_chk++;
        if (qget(r_data, 0) !== 5 || qget(r_id, 0) !== 0) $display("FAIL b2b_resp0: got data=%0d id=%0d, 5/0 required", qget(r_data, 0), qget(r_id, 0));
        else n_pass++;
        n_chk++;
        if (qget(r_data, 1) !== 6 || qget(r_id, 1) !== 1) $display("FAIL b2b_resp1: got data=%0d id=%0d, 6/1 required", qget(r_data, 1), qget(r_id, 1));
        else n_pass++;
        n_chk++;
        if (qget(r_cyc, 1) !== qget(r_cyc, 0) + 1 || s_cyc.size() != 0)
            $display("FAIL b2b_timing: got resp cyc %0d starts=%0d, cyc %0d starts 0 required", qget(r_cyc, 1), s_cyc.size(), qget(r_cyc, 0) + 1);
        else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        core_lat = 30;
        clear_log();
        add_job(0, 18'd1, 18'd262143);
        serve(1, 5);
        n_chk++;
        if (busy !== 1'b1 || gcd_start !== 1'b0) $display("FAIL rst_wait_pre: got busy=%b start=%b, 1/0 required", busy, gcd_start);
        else n_pass++;
        req_valid = '0; req_a = '0; req_b = '0;
        reset_n = 1'b0;
        #1;
        n_chk++;
        if ({req_ready, resp_valid, resp_id, resp_data, busy, gcd_start, gcd_a, gcd_b} !== '0)
            $display("FAIL rst_wait_outputs: got rv=%b data=%0d busy=%b start=%b a=%0d b=%0d, all 0 required",
                     resp_valid, resp_data, busy, gcd_start, gcd_a, gcd_b);
        else n_pass++;
        n_chk++;
        if (gcd_result_ready !== 1'b0) $display("FAIL rst_wait_core_busy: got %b, 0 required", gcd_result_ready);
        else n_pass++;
        step();
        reset_n = 1'b1;
        clear_log();
        add_job(1, 18'd10, 18'd4);
        serve(1, 150);
        n_chk++;
        if (r_id.size() != 1 || qget(r_id, 0) !== 1 || qget(r_data, 0) !== 2)
            $display("FAIL rst_wait_resp: got n=%0d id=%0d data=%0d, n=1 id=1 data=2 required", r_id.size(), qget(r_id, 0), qget(r_data, 0));
        else n_pass++;
        n_chk++;
        if (grant_while_busy != 0 || blocked == 0)
            $display("FAIL rst_wait_block: got grants while busy=%0d blocked cycles=%0d, 0 and >0 required", grant_while_busy, blocked);
        else n_pass++;
        core_lat = 6;
    endtask

    task automatic test_busy_core();
        clear_log();
        force_busy = 1'b1;
        add_job(3, 18'd20, 18'd30);
        serve(1, 8);
        n_chk++;
        if (g_id.size() != 0 || blocked < 8) $display("FAIL busy_core_block: got %0d grants blocked=%0d, 0 grants 8 blocked required", g_id.size(), blocked);
        else n_pass++;
        force_busy = 1'b0;
        serve(1, 60);
        n_chk++;
        if (g_id.size() != 1 || qget(g_id, 0) !== 3) $display("FAIL busy_core_grant: got n=%0d id=%0d, n=1 id=3 required", g_id.size(), qget(g_id, 0));
        else n_pass++;
        n_chk++;
        if (qget(r_data, 0) !== 10 || qget(r_id, 0) !== 3) $display("FAIL busy_core_resp: got data=%0d id=%0d, 10/3 required", qget(r_data, 0), qget(r_id, 0));
        else n_pass++;
    endtask

    initial begin
        reset_n    = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        exp_ga     = '0;
        exp_gb     = '0;
        last_grant = -1;
        clear_log();
        test_reset();
        test_single();
        test_bypass();
        test_round_robin();
        test_back_to_back();
        test_reset_mid_wait();
        test_busy_core();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
